// File: rtl/lia_boxcar_avg.sv
// Boxcar averager for the lock-in output: sums 2^L valid samples, then emits
// the floor-rounded mean as a one-cycle strobe and starts the next window.
module lia_boxcar_avg #(
   parameter int DW     = 14,
   parameter int MAXLOG = 12
) (
   input  logic          dac_clk_i,
   input  logic          dac_rstn_i,
   input  logic          en_i,
   input  logic [3:0]    log2_len_i,
   input  logic [DW-1:0] lia_dat_i,
   input  logic          lia_vld_i,
   output logic [DW-1:0] avg_dat_o,
   output logic          avg_vld_o,
   output logic          busy_o
);

   localparam int AW = DW + MAXLOG;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic [MAXLOG-1:0]      cnt_q, cnt_d;
   logic [3:0]             len_q, len_d;
   logic [DW-1:0]          avg_q, avg_d;
   logic                   vld_q, vld_d;

   logic [3:0]             len_req;
   logic signed [AW-1:0]   sum;
   logic [MAXLOG-1:0]      last_cnt;

   // Requested window length, clamped so the accumulator can never wrap.
   always_comb begin
      len_req = (log2_len_i > 4'(MAXLOG)) ? 4'(MAXLOG) : log2_len_i;
   end

   always_comb begin
      sum      = acc_q + {{MAXLOG{lia_dat_i[DW-1]}}, lia_dat_i};
      last_cnt = ~({MAXLOG{1'b1}} << len_q);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      avg_d   = avg_q;
      vld_d   = 1'b0;
      case (state_q)
         IDLE: begin
            acc_d = '0;
            cnt_d = '0;
            if (en_i) begin
               state_d = ACCUM;
               len_d   = len_req;
            end
         end
         ACCUM: begin
            if (!en_i) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end else if (lia_vld_i) begin
               if (cnt_q == last_cnt) begin
                  // Window closes on this sample; next window starts with no gap.
                  avg_d = DW'(sum >>> len_q);
                  vld_d = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
                  len_d = len_req;
               end else begin
                  acc_d = sum;
                  cnt_d = cnt_q + MAXLOG'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge dac_clk_i) begin
      if (!dac_rstn_i) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         avg_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         avg_q   <= avg_d;
         vld_q   <= vld_d;
      end
   end

   assign avg_dat_o = avg_q;
   assign avg_vld_o = vld_q;
   assign busy_o    = (state_q == ACCUM);

endmodule

// File: tb/tb_lia_boxcar_avg.sv
// Directed bench for lia_boxcar_avg: stimulus pushes expected averages and
// their strobe cycle; a negedge monitor pops and compares on each strobe.
module tb_lia_boxcar_avg;

   localparam int DW     = 14;
   localparam int MAXLOG = 12;

   logic          clk;
   logic          rstn;
   logic          en;
   logic [3:0]    log2_len;
   logic [DW-1:0] dat;
   logic          vld;
   logic [DW-1:0] avg_dat;
   logic          avg_vld;
   logic          busy;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_cnt = 0;
   int   n_cmp   = 0;
   int   n_err   = 0;

   lia_boxcar_avg #(.DW(DW), .MAXLOG(MAXLOG)) dut (
      .dac_clk_i  (clk),
      .dac_rstn_i (rstn),
      .en_i       (en),
      .log2_len_i (log2_len),
      .lia_dat_i  (dat),
      .lia_vld_i  (vld),
      .avg_dat_o  (avg_dat),
      .avg_vld_o  (avg_vld),
      .busy_o     (busy)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Monitor: every strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (avg_vld) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("avg_value", $signed(avg_dat), e.val);
            check("avg_cycle", cyc_cnt, e.cyc);
         end
      end
   end

   task automatic drive(input logic e, input logic v, input int d);
      en  = e;
      vld = v;
      dat = DW'(d);
      @(posedge clk);
      #1;
   endtask

   // Present one valid sample; if it closes a window, expect the average next cycle.
   task automatic feed(input int d, input bit last, input int avg);
      exp_t e;
      if (last) begin
         e.val = avg;
         e.cyc = cyc_cnt + 1;
         exp_q.push_back(e);
      end
      drive(1'b1, 1'b1, d);
   endtask

   initial begin
      rstn     = 1'b0;
      en       = 1'b1;
      vld      = 1'b1;
      dat      = DW'(321);
      log2_len = 4'd2;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("rst_avg", $signed(avg_dat), 0);
      check("rst_vld", int'(avg_vld), 0);
      check("rst_busy", int'(busy), 0);

      rstn = 1'b1;
      drive(1'b0, 1'b1, 77);
      check("idle_busy", int'(busy), 0);
      drive(1'b1, 1'b1, 999);
      check("start_busy", int'(busy), 1);

      for (int i = 0; i < 4; i++) feed(100, i == 3, 100);

      // Back-to-back window; log2_len change mid-window applies next window only.
      feed(-1, 0, 0);
      log2_len = 4'd0;
      feed(-1, 0, 0);
      feed(-1, 0, 0);
      feed(0, 1, -1);

      feed(5, 1, 5);
      log2_len = 4'd3;
      feed(-7, 1, -7);

      // L=3 with gaps: valid values 1..8 on even cycles, sum 36 -> 4.
      for (int i = 0; i < 16; i++) begin
         if (i == 6) log2_len = 4'd1;
         if (i % 2 == 0) feed(i / 2 + 1, i == 14, 4);
         else drive(1'b1, 1'b0, 777);
      end
      feed(3, 0, 0);
      log2_len = 4'd15;
      feed(4, 1, 3);

      // Requested 15 clamps to 12: full-scale windows must not wrap.
      for (int i = 0; i < 4096; i++) feed(8191, i == 4095, 8191);
      for (int i = 0; i < 4096; i++) feed(-8192, i == 4095, -8192);
      drive(1'b1, 1'b0, 0);
      drive(1'b1, 1'b0, 0);
      check("hold_avg", $signed(avg_dat), -8192);
      check("hold_vld", int'(avg_vld), 0);

      drive(1'b0, 1'b1, 123);
      check("dis_busy", int'(busy), 0);
      check("dis_avg", $signed(avg_dat), -8192);
      log2_len = 4'd2;
      drive(1'b1, 1'b1, 999);
      check("restart_busy", int'(busy), 1);
      for (int i = 0; i < 3; i++) feed(10, 0, 0);
      drive(1'b0, 1'b1, 10);
      check("abort_busy", int'(busy), 0);
      drive(1'b0, 1'b0, 0);
      drive(1'b1, 1'b1, 50);
      check("reen_busy", int'(busy), 1);
      feed(20, 0, 0);
      feed(20, 0, 0);
      feed(20, 0, 0);
      feed(24, 1, 21);

      for (int i = 0; i < 4; i++) feed(55, i == 3, 55);
      check("pre_rst_avg", $signed(avg_dat), 55);
      feed(7, 0, 0);
      feed(7, 0, 0);
      rstn = 1'b0;
      drive(1'b1, 1'b1, 7);
      check("midrst_avg", $signed(avg_dat), 0);
      check("midrst_vld", int'(avg_vld), 0);
      check("midrst_busy", int'(busy), 0);
      rstn = 1'b1;
      drive(1'b1, 1'b1, 999);
      check("post_rst_busy", int'(busy), 1);
      feed(1, 0, 0);
      feed(2, 0, 0);
      feed(3, 0, 0);
      feed(4, 1, 2);

      repeat (4) drive(1'b0, 1'b0, 0);
      check("pending_left", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lia_boxcar_avg.md
LIA_BOXCAR_AVG -- requirements
Module: lia_boxcar_avg

Interface
REQ-001 The block SHALL have parameter DW, default 14, giving the signed sample width.
REQ-002 The block SHALL have parameter MAXLOG, default 12, giving the largest log2 window length.
REQ-003 The block SHALL have port dac_clk_i, input, 1 bit: the 125 MHz clock; all logic is on its rising edge.
REQ-004 The block SHALL have port dac_rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en_i, input, 1 bit: averaging enable.
REQ-006 The block SHALL have port log2_len_i, input, 4 bits: log2 of the window length N.
REQ-007 The block SHALL have port lia_dat_i, input, DW bits: two's-complement sample from the lock-in output stage.
REQ-008 The block SHALL have port lia_vld_i, input, 1 bit: lia_dat_i is valid this cycle.
REQ-009 The block SHALL have port avg_dat_o, output, DW bits: two's-complement window average.
REQ-010 The block SHALL have port avg_vld_o, output, 1 bit: one-cycle strobe marking a new avg_dat_o.
REQ-011 The block SHALL have port busy_o, output, 1 bit: high while a window is accumulating.

Function
REQ-012 The block SHALL implement two states, IDLE and ACCUM; busy_o SHALL equal (state == ACCUM).
REQ-013 In IDLE with en_i=1, the block SHALL go to ACCUM on the next edge, clear the accumulator and sample counter, and latch L = min(log2_len_i, MAXLOG).
REQ-014 In IDLE, samples SHALL be ignored, including one presented in the IDLE->ACCUM transition cycle.
REQ-015 In ACCUM with en_i=1 and lia_vld_i=1, the block SHALL add the sign-extended lia_dat_i to the accumulator and increment the counter.
REQ-016 Cycles with lia_vld_i=0 SHALL not count; a window is N = 2^L valid samples, regardless of gaps.
REQ-017 The accumulator SHALL be signed, DW+MAXLOG bits wide, and SHALL never wrap.
REQ-018 When the Nth valid sample is consumed (counter == N-1 and lia_vld_i=1), on that same edge the block SHALL:
  - register avg_dat_o = (acc + sample) >>> L (arithmetic shift, rounding toward minus infinity, no saturation needed);
  - set avg_vld_o=1 for exactly one cycle;
  - clear the accumulator and counter;
  - re-latch L from log2_len_i;
  - remain in ACCUM.
REQ-019 Latency SHALL be 1 cycle from the Nth sample to avg_vld_o; back-to-back windows SHALL drop no samples.
REQ-020 Changes on log2_len_i mid-window SHALL be ignored until the next window start.
REQ-021 With L=0, every valid sample SHALL appear on avg_dat_o unchanged, 1 cycle later, with avg_vld_o=1.
REQ-022 With en_i=0 in ACCUM, the block SHALL, on the next edge:
  - go to IDLE;
  - clear the accumulator and counter;
  - discard the partial window with no strobe;
  - ignore any sample presented that cycle.
REQ-023 avg_dat_o SHALL hold its last value between strobes and through IDLE.
REQ-024 avg_vld_o SHALL be 0 in every cycle not defined by REQ-018.

Reset
REQ-025 With dac_rstn_i=0 at an edge, the block SHALL set: state IDLE, accumulator 0, counter 0, L 0, avg_dat_o 0, avg_vld_o 0, busy_o 0.
REQ-026 Reset SHALL override en_i and lia_vld_i, and SHALL abort any window in progress with no strobe.
REQ-027 After reset release, the first window SHALL start only via REQ-013.

Verification
REQ-028 Scenario L=2, samples 100,100,100,100 with lia_vld_i every cycle -> avg_dat_o=100 and a single avg_vld_o pulse the cycle after the 4th sample.
REQ-029 Scenario L=2, samples -1,-1,-1,0 -> avg_dat_o=-1 (sum -3 >>> 2).
REQ-030 Scenario L=12, 4096 samples of 8191 then 4096 samples of -8192 -> outputs 8191 then -8192, no wrap, pulses 4096 valid samples apart.
REQ-031 Scenario L=3, lia_vld_i toggling 1010... -> one pulse per 8 valid samples (16 cycles); changing log2_len_i to 1 mid-window takes effect only in the following window.
REQ-032 Scenario L=2, en_i dropped after 3 samples, then re-raised -> no pulse for the partial window; the next pulse follows 4 fresh samples; busy_o tracks the state.
REQ-033 Scenario: dac_rstn_i=0 mid-window after a prior avg_dat_o=55 -> next cycle avg_dat_o=0, avg_vld_o=0, busy_o=0, and no pulse.
